fpmul_arbiter: RTL and testbench
================================

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port req_valid, input, 2 bits: bit i is requester i's operand-valid.
REQ-004 SHALL have port req_ready, output, 2 bits: bit i means requester i's operands are accepted this cycle.
REQ-005 SHALL have ports req_x0, req_y0, req_x1, req_y1, input, 32 bits each: IEEE-754 single-precision operands per requester.
REQ-006 SHALL have port resp_valid, output, 2 bits: bit i means the result belongs to requester i.
REQ-007 SHALL have port resp_ready, input, 2 bits: bit i means requester i consumes the result.
REQ-008 SHALL have port resp_result, output, 32 bits: shared product bus.
REQ-009 SHALL have port resp_flags, output, 5 bits: {inf, nan, zero, overflow, underflow}.
REQ-010 SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-011 SHALL have port flag_count, output, 16 bits: saturating count of responses with any flag set.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one multiply in flight.
REQ-013 IDLE: SHALL compute grant combinationally and drive req_ready = onehot(grant) only while state==IDLE and req_valid[grant]=1.
  - Otherwise req_ready SHALL be 2'b00.
REQ-014 Grant SHALL be round-robin.
  - Only one requester valid: that one is granted.
  - Both valid: the requester named by the priority pointer is granted.
  - Pointer SHALL be 0 after reset and SHALL flip to the other requester after each accepted transfer.
REQ-015 On accept (req_valid[g] & req_ready[g]): SHALL latch the granted X/Y into operand registers, record owner=g, and go to EXEC.
REQ-016 EXEC (exactly one cycle): SHALL feed the operand registers to the multiply core, register its 32-bit result and 5 flags, and go to RESP.
REQ-017 RESP: SHALL assert resp_valid[owner] only, holding resp_result and resp_flags stable.
  - Leave to IDLE on the cycle resp_ready[owner]=1.
  - resp_ready of the non-owner SHALL be ignored.
REQ-018 Latency: accept in cycle N -> resp_valid high in cycle N+2; best-case issue interval 3 cycles.
REQ-019 A new request SHALL NOT be accepted in the cycle RESP completes; it is accepted in the next IDLE cycle at the earliest.
REQ-020 Outside RESP, resp_valid SHALL be 2'b00; resp_result and resp_flags hold their last value.
REQ-021 flag_count SHALL increment by 1 on each completed response handshake with resp_flags != 0.
  - It saturates at 16'hFFFF and never wraps.
REQ-022 Result/flag semantics SHALL be exactly those of the multiply core:
  - zero has precedence over nan, nan over inf, then underflow, then overflow.
  - Result is truncated (not rounded).

Reset
REQ-023 reset_n low SHALL asynchronously force:
  - state=IDLE, pointer=0, owner=0;
  - resp_valid=0, req_ready=0, resp_result=0, resp_flags=0, flag_count=0, busy=0.
REQ-024 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is produced after reset release.
REQ-025 The first accept SHALL occur no earlier than the first rising edge after reset_n deasserts.

Structure
REQ-026 A shared package SHALL hold:
  - the FSM state enum (IDLE, EXEC, RESP);
  - the flag-vector bit-index constants (INF=4, NAN=3, ZERO=2, OVF=1, UNF=0);
  - constants EXP_MAX=8'd255 and BIAS=8'd127.
REQ-027 The multiply SHALL be one combinational sub-module, fp32_mul_core (X, Y -> result, 5 flags), instantiated once and shared.

Verification
REQ-028 Basic multiply: req_x0=32'h40000000, req_y0=32'h40400000 -> resp_valid=2'b01 two cycles after accept, resp_result=32'h40C00000, resp_flags=5'b00000.
REQ-029 Zero operand: req_x1=32'h00000000, req_y1=32'h3F800000 -> resp_valid=2'b10, resp_result=0, resp_flags=5'b00100, flag_count +1.
REQ-030 Contention: both requesters valid right after reset -> requester 0 served first, requester 1 second; with both continuously valid, grants alternate 0,1,0,1.
REQ-031 Backpressure: resp_ready low for 5 cycles in RESP -> result and flags stable, req_ready=00 throughout, exit one cycle after resp_ready[owner] rises.
REQ-032 NaN then reset:
  - 32'h7FC00000 x 32'h3F800000 -> resp_result=32'h7F800000, resp_flags=5'b01000.
  - Then reset_n pulsed low during EXEC of the next operation -> all outputs 0 immediately, no response after release.

Source files
------------

// File: rtl/fpmul_arbiter_pkg.sv
// Shared types and constants for the two-requester FP32 multiply arbiter.
package fpmul_arbiter_pkg;

  localparam int unsigned FP_W   = 32;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned CNT_W  = 16;

  // Bit positions inside the {inf, nan, zero, overflow, underflow} flag vector
  localparam int unsigned INF  = 4;
  localparam int unsigned NAN  = 3;
  localparam int unsigned ZERO = 2;
  localparam int unsigned OVF  = 1;
  localparam int unsigned UNF  = 0;

  localparam logic [7:0] EXP_MAX = 8'd255;
  localparam logic [7:0] BIAS    = 8'd127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [FP_W-1:0] x;
    logic [FP_W-1:0] y;
  } operands_t;

  typedef struct packed {
    logic [FP_W-1:0]   result;
    logic [FLAG_W-1:0] flags;
  } product_t;

endpackage

// File: rtl/fpmul_arbiter_mul.sv
// Combinational FP32 multiply: truncating, denormals read as zero,
// special-case precedence zero > nan > inf > underflow > overflow.
module fp32_mul_core
  import fpmul_arbiter_pkg::*;
(
  input  logic [FP_W-1:0]   x_i,
  input  logic [FP_W-1:0]   y_i,
  output logic [FP_W-1:0]   result_o,
  output logic [FLAG_W-1:0] flags_o
);

  logic        sign_c;
  logic [7:0]  ex_c, ey_c;
  logic [22:0] mx_c, my_c;
  logic        x_zero_c, y_zero_c, x_nan_c, y_nan_c, x_inf_c, y_inf_c;
  logic [47:0] prod_c;
  logic [9:0]  exp_c;
  logic [22:0] man_c;
  logic        under_c, over_c;
  logic        unused_prod_lsb;

  assign sign_c = x_i[31] ^ y_i[31];
  assign ex_c   = x_i[30:23];
  assign ey_c   = y_i[30:23];
  assign mx_c   = x_i[22:0];
  assign my_c   = y_i[22:0];

  assign x_zero_c = (ex_c == 8'd0);
  assign y_zero_c = (ey_c == 8'd0);
  assign x_nan_c  = (ex_c == EXP_MAX) && (mx_c != 23'd0);
  assign y_nan_c  = (ey_c == EXP_MAX) && (my_c != 23'd0);
  assign x_inf_c  = (ex_c == EXP_MAX) && (mx_c == 23'd0);
  assign y_inf_c  = (ey_c == EXP_MAX) && (my_c == 23'd0);

  assign prod_c = {24'd0, 1'b1, mx_c} * {24'd0, 1'b1, my_c};

  // Product of two [1,2) mantissas lies in [1,4); bit 47 means renormalise by one
  assign man_c = prod_c[47] ? prod_c[46:24] : prod_c[45:23];
  assign exp_c = {2'b00, ex_c} + {2'b00, ey_c} + {9'd0, prod_c[47]} - {2'b00, BIAS};

  // Biased exponent range is -125..382, so bit 9 is a reliable sign bit
  assign under_c = exp_c[9] || (exp_c == 10'd0);
  assign over_c  = !exp_c[9] && (exp_c >= 10'(EXP_MAX));

  assign unused_prod_lsb = ^prod_c[22:0];

  always_comb begin
    result_o = '0;
    flags_o  = '0;
    if (x_zero_c || y_zero_c) begin
      result_o      = {sign_c, 31'd0};
      flags_o[ZERO] = 1'b1;
    end else if (x_nan_c || y_nan_c) begin
      result_o     = {sign_c, EXP_MAX, 23'd0};
      flags_o[NAN] = 1'b1;
    end else if (x_inf_c || y_inf_c) begin
      result_o     = {sign_c, EXP_MAX, 23'd0};
      flags_o[INF] = 1'b1;
    end else if (under_c) begin
      result_o     = {sign_c, 31'd0};
      flags_o[UNF] = 1'b1;
    end else if (over_c) begin
      result_o     = {sign_c, EXP_MAX, 23'd0};
      flags_o[OVF] = 1'b1;
    end else begin
      result_o = {sign_c, exp_c[7:0], man_c};
    end
  end

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one FP32 multiplier between two requesters;
// one operation in flight, accept -> EXEC -> RESP with response backpressure.
module fpmul_arbiter
  import fpmul_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [FP_W-1:0]   req_x0,
  input  logic [FP_W-1:0]   req_y0,
  input  logic [FP_W-1:0]   req_x1,
  input  logic [FP_W-1:0]   req_y1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [FP_W-1:0]   resp_result,
  output logic [FLAG_W-1:0] resp_flags,
  output logic              busy,
  output logic [CNT_W-1:0]  flag_count
);

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               owner_q;
  operands_t          ops_q;
  product_t           prod_q;
  logic [CNT_W-1:0]   flag_count_q, flag_count_d;
  logic               grant_c, accept_c, resp_done_c;
  logic [FP_W-1:0]    core_res_c;
  logic [FLAG_W-1:0]  core_flags_c;

  // A lone requester wins outright; on contention the pointer decides
  assign grant_c     = (req_valid == 2'b11) ? ptr_q : req_valid[1];
  assign accept_c    = reset_n && (state_q == IDLE) && req_valid[grant_c];
  assign resp_done_c = (state_q == RESP) && resp_ready[owner_q];

  fp32_mul_core u_mul (
    .x_i      (ops_q.x),
    .y_i      (ops_q.y),
    .result_o (core_res_c),
    .flags_o  (core_flags_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_done_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    busy       = (state_q != IDLE);
    if (accept_c)          req_ready  = grant_c ? 2'b10 : 2'b01;
    if (state_q == RESP)   resp_valid = owner_q ? 2'b10 : 2'b01;
  end

  always_comb begin
    ptr_d        = ptr_q;
    flag_count_d = flag_count_q;
    if (accept_c) ptr_d = ~ptr_q;
    if (resp_done_c && (prod_q.flags != '0) && (flag_count_q != '1))
      flag_count_d = flag_count_q + CNT_W'(1);
  end

  // Operand capture on accept, product capture at the end of EXEC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      ops_q        <= '0;
      prod_q       <= '0;
      flag_count_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      flag_count_q <= flag_count_d;
      if (accept_c) begin
        owner_q <= grant_c;
        ops_q   <= grant_c ? operands_t'({req_x1, req_y1}) : operands_t'({req_x0, req_y0});
      end
      if (state_q == EXEC) begin
        prod_q.result <= core_res_c;
        prod_q.flags  <= core_flags_c;
      end
    end
  end

  assign resp_result = prod_q.result;
  assign resp_flags  = prod_q.flags;
  assign flag_count  = flag_count_q;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter: vector table plus arbitration,
// backpressure and reset-in-flight sequences, with a response scoreboard.
module tb_fpmul_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_x0, req_y0, req_x1, req_y1, resp_result;
  logic [4:0]  resp_flags;
  logic        busy;
  logic [15:0] flag_count;

  always #5 clk = ~clk;

  fpmul_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x0      (req_x0),
    .req_y0      (req_y0),
    .req_x1      (req_x1),
    .req_y1      (req_y1),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .busy        (busy),
    .flag_count  (flag_count)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic [4:0]  flg;
  } tv_t;

  typedef struct {
    int          owner;
    logic [31:0] res;
    logic [4:0]  flg;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          acc_log[$];
  logic [31:0] exp_res[2];
  logic [4:0]  exp_flg[2];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push on accept, check latency/owner, pop and compare on handshake
  always @(negedge clk) begin
    int g;
    if (reset_n === 1'b1) begin
      if (resp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          chk("spurious_resp_valid", 32'(resp_valid), 32'd0);
        end else begin
          if (!sb[0].seen) begin
            sb[0].seen = 1'b1;
            chk("latency", 32'(cyc - sb[0].acc), 32'd2);
            chk("resp_valid_owner", 32'(resp_valid), (sb[0].owner == 1) ? 32'd2 : 32'd1);
          end
          if (resp_ready[sb[0].owner]) begin
            chk("resp_result", resp_result, sb[0].res);
            chk("resp_flags", 32'(resp_flags), 32'(sb[0].flg));
            chk("flag_count", 32'(flag_count), 32'(exp_cnt));
            if (sb[0].flg != 5'd0 && exp_cnt < 65535) exp_cnt++;
            void'(sb.pop_front());
          end
        end
      end
      if ((req_valid & req_ready) != 2'b00) begin
        g = req_ready[1] ? 1 : 0;
        sb.push_back('{owner: g, res: exp_res[g], flg: exp_flg[g], acc: cyc, seen: 1'b0});
        grant_log.push_back(g);
        acc_log.push_back(cyc);
      end
    end
  end

  task automatic set_req(input int r, input tv_t v);
    if (r == 0) begin req_x0 = v.x; req_y0 = v.y; end
    else        begin req_x1 = v.x; req_y1 = v.y; end
    exp_res[r] = v.res;
    exp_flg[r] = v.flg;
  endtask

  // Present one request and return one cycle after its accept (in EXEC)
  task automatic issue(input int r, input tv_t v);
    int t;
    @(posedge clk); #1;
    set_req(r, v);
    req_valid[r] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (req_ready[r] !== 1'b1 && t < 50);
    if (req_ready[r] !== 1'b1) fail_now("accept_timeout");
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail_now("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv_t tv[11];
    int  t;
    tv[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 5'b00000}; // 2*3
    tv[1]  = '{32'h00000000, 32'h3F800000, 32'h00000000, 5'b00100}; // 0*1
    tv[2]  = '{32'h7FC00000, 32'h3F800000, 32'h7F800000, 5'b01000}; // nan*1
    tv[3]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 5'b10000}; // inf*2
    tv[4]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 5'b00000}; // -2*3
    tv[5]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b00010}; // overflow
    tv[6]  = '{32'h00800000, 32'h00800000, 32'h00000000, 5'b00001}; // underflow
    tv[7]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 5'b00000}; // 1.5*1.5
    tv[8]  = '{32'h00000000, 32'h7FC00000, 32'h00000000, 5'b00100}; // zero beats nan
    tv[9]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00000}; // truncation
    tv[10] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000}; // 1*1

    reset_n    = 1'b0;
    resp_ready = 2'b11;
    req_valid  = 2'b00;
    set_req(0, tv[0]);
    set_req(1, tv[1]);
    req_valid  = 2'b11;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_resp_flags", 32'(resp_flags), 32'd0);
    chk("rst_flag_count", 32'(flag_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Contention straight out of reset: both stay valid for four grants
    @(posedge clk); #1;
    reset_n = 1'b1;
    t = 0;
    while (grant_log.size() < 4 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (grant_log.size() < 4) fail_now("contention_timeout");
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk("rr_grant", 32'(grant_log[k]), 32'(k % 2));
    for (int k = 1; k < 4 && k < acc_log.size(); k++)
      chk("issue_interval", 32'(acc_log[k] - acc_log[k-1]), 32'd3);

    for (int k = 0; k < 11; k++) begin
      issue(k % 2, tv[k]);
      drain();
    end

    // Backpressure on requester 0 while requester 1 waits
    resp_ready = 2'b00;
    issue(0, tv[7]);
    set_req(1, tv[5]);
    req_valid[1] = 1'b1;
    resp_ready   = 2'b10;
    @(negedge clk);
    chk("bp_exec_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_result_stable", resp_result, 32'h40100000);
      chk("bp_flags_stable", 32'(resp_flags), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("bp_exit_busy", 32'(busy), 32'd0);
    chk("bp_exit_req_ready", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain();

    // NaN result, then reset while the next operation is in EXEC
    issue(0, tv[2]);
    drain();
    issue(1, tv[0]);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_resp_valid", 32'(resp_valid), 32'd0);
    chk("rr_req_ready", 32'(req_ready), 32'd0);
    chk("rr_resp_result", resp_result, 32'd0);
    chk("rr_resp_flags", 32'(resp_flags), 32'd0);
    chk("rr_flag_count", 32'(flag_count), 32'd0);
    sb.delete();
    exp_cnt = 0;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    issue(1, tv[3]);
    drain();
    chk("final_flag_count", 32'(flag_count), 32'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
